// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Frame: count (big-endian), data words (big-endian), checksum byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_CNT_HI = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int CHK_W          = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam int FLD_CNT_HI = 0;
  localparam int FLD_CNT_LO = 1;
  localparam int FLD_DATA   = 2;
  localparam int FLD_CSUM   = 3;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts bytes into a 32-bit big-endian word.
// Pulses word_valid the cycle after the last byte of a word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clr) begin
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= byte_en && (byte_cnt == LAST);
      if (byte_en) begin
        word     <= {word[23:0], byte_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a framed byte stream
// and releases the core once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  state_t             state, state_n;
  logic [7:0]         cnt_hi;
  logic [15:0]        n_words;
  logic [15:0]        n_in;
  logic [IDX_W-1:0]   idx;
  logic [CHK_W-1:0]   acc;
  logic               accept;
  logic               restart_ok;
  logic               last_word;
  logic [1:0]         byte_cnt;

  assign in_ready   = (state != ST_DONE) && (state != ST_ERROR);
  assign accept     = in_valid && in_ready;
  assign restart_ok = restart && !in_ready;
  assign n_in       = {cnt_hi, in_data};
  assign last_word  = (17'(idx) + 17'd1) == 17'(n_words);

  // Address follows the word index, which advances after each write.
  assign mem_wr_addr = ADDR_W'(BASE_ADDR) + (ADDR_W'(idx) << 2);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart_ok),
    .byte_en    (accept && (state == ST_DATA)),
    .byte_data  (in_data),
    .byte_cnt   (byte_cnt),
    .word_valid (mem_wr_en),
    .word       (mem_wr_data)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_CNT_HI: if (accept) state_n = ST_CNT_LO;
      ST_CNT_LO: begin
        if (accept) begin
          if (n_in > 16'(MAX_WORDS)) state_n = ST_ERROR;
          else if (n_in == 16'd0)    state_n = ST_CSUM;
          else                       state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && byte_cnt == 2'(BYTES_PER_WORD - 1) && last_word)
          state_n = ST_CSUM;
      end
      ST_CSUM: begin
        if (accept) state_n = (in_data == acc) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  if (restart) state_n = ST_CNT_HI;
      ST_ERROR: if (restart) state_n = ST_CNT_HI;
      default:  state_n = ST_CNT_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CNT_HI;
      cnt_hi   <= '0;
      n_words  <= '0;
      idx      <= '0;
      acc      <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      cpu_hold <= (state_n != ST_DONE);
      done     <= (state_n == ST_DONE);
      error    <= (state_n == ST_ERROR);
      if (accept && state == ST_CNT_HI) cnt_hi <= in_data;
      if (accept && state == ST_CNT_LO) n_words <= n_in;
      if (restart_ok) begin
        idx <= '0;
        acc <= '0;
      end else begin
        if (mem_wr_en) idx <= idx + 1'b1;
        if (accept && state == ST_DATA) acc <= acc + in_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, errors, reset, gaps.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  imem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .restart     (restart),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wa.push_back(mem_wr_addr);
      wd.push_back(mem_wr_data);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit r;
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!r && guard < 50);
    in_valid = 1'b0;
    if (!r) check("send_timeout", 32'(guard), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] csum, input bit gaps);
    logic [7:0] f[11];
    f = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
    f[10] = csum;
    for (int i = 0; i < 11; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      restart = gaps && (i == 5);
      send(f[i]);
      restart = 1'b0;
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() >= 2) begin
      check({tag, "_a0"}, wa[0], 32'h0);
      check({tag, "_d0"}, wd[0], 32'hDEADBEEF);
      check({tag, "_a1"}, wa[1], 32'h4);
      check({tag, "_d1"}, wd[1], 32'h01234567);
    end
  endtask

  task automatic pulse_restart(input bit with_byte);
    restart  = 1'b1;
    in_valid = with_byte;
    in_data  = 8'h00;
    @(posedge clk);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    restart = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_wen", 32'(mem_wr_en), 32'd0);
    check("rst_addr", mem_wr_addr, 32'h0);
    check("rst_data", mem_wr_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // good frame, no gaps
    clear_log();
    send_frame(8'h08, 1'b0);
    check("good_done", 32'(done), 32'd1);
    check("good_hold", 32'(cpu_hold), 32'd0);
    check("good_rdy", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_writes("good");

    // restart with a byte offered at the same time
    pulse_restart(1'b1);
    check("rs_ready", 32'(in_ready), 32'd1);
    check("rs_done", 32'(done), 32'd0);
    check("rs_hold", 32'(cpu_hold), 32'd1);

    // empty image
    clear_log();
    send(8'h00); send(8'h00); send(8'h00);
    check("empty_done", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("empty_nwr", 32'(wa.size()), 32'd0);
    pulse_restart(1'b0);

    // oversize count
    clear_log();
    send(8'h00); send(8'h41);
    check("over_err", 32'(error), 32'd1);
    check("over_rdy", 32'(in_ready), 32'd0);
    check("over_hold", 32'(cpu_hold), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("over_nwr", 32'(wa.size()), 32'd0);
    check("over_err2", 32'(error), 32'd1);
    pulse_restart(1'b0);

    // bad checksum, then recover
    clear_log();
    send_frame(8'h09, 1'b0);
    check("bad_err", 32'(error), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_hold", 32'(cpu_hold), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_writes("bad");
    pulse_restart(1'b0);
    check("bad_rs_rdy", 32'(in_ready), 32'd1);
    check("bad_rs_err", 32'(error), 32'd0);
    clear_log();
    send_frame(8'h08, 1'b0);
    check("rec_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    check_writes("rec");
    pulse_restart(1'b0);

    // reset mid-word
    clear_log();
    send(8'h00); send(8'h02); send(8'hDE); send(8'hAD);
    rst = 1'b1;
    #1;
    check("mr_wen", 32'(mem_wr_en), 32'd0);
    check("mr_hold", 32'(cpu_hold), 32'd1);
    check("mr_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(8'h08, 1'b0);
    check("mr_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    check_writes("mr");
    pulse_restart(1'b0);

    // random gaps, restart mid-frame must be ignored
    clear_log();
    send_frame(8'h08, 1'b1);
    check("gap_done", 32'(done), 32'd1);
    check("gap_hold", 32'(cpu_hold), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      check("gap_dn_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("gap_dn_done", 32'(done), 32'd1);
    check_writes("gap");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
